task_loader: RTL
================

# task_loader

Upstream stream-to-regfile loader for `accelerator_top`. It accepts a word stream from the host side: one header word, then the InexRecur table words, then the initial search-state words. It drives the `ran_we_InexRecur` and `ran_we_state_external` random write ports of the accelerator. When the last word has been committed, it issues a single-cycle `is_start` pulse, so software never sequences the three inputs by hand.

## Interface
Parameters:
- `ADDR_W`, 12, regfile address width; also the width of each count field in the header.
- `RECUR_W`, 32, InexRecur entry width (equal to the stream word width).
- `STATE_W`, 18, state entry width; taken from `in_data[STATE_W-1:0]`.

Ports:
- `clk` in 1 — the single clock.
- `rst_n` in 1 — reset, asynchronous and active-low.
- `in_valid` in 1 — stream word valid.
- `in_data` in 32 — stream word.
- `in_ready` out 1 — loader can accept a word this cycle.
- `ran_we_InexRecur` out 1 — InexRecur write enable.
- `ran_w_addr_InexRecur` out ADDR_W — InexRecur write address.
- `ran_w_data_InexRecur` out RECUR_W — InexRecur write data.
- `ran_we_state_external` out 1 — state write enable.
- `ran_w_addr_state_external` out ADDR_W — state write address.
- `ran_w_data_state_external` out STATE_W — state write data.
- `is_start` out 1 — one-cycle start pulse to the accelerator.
- `busy_o` out 1 — high from header acceptance until the `is_start` cycle, inclusive.

## Operation
- **Handshake:** a word transfers on any rising edge where `in_valid && in_ready`.
- **Header word:**
  - `n_recur = in_data[11:0]`, `n_state = in_data[23:12]`.
  - Bits `[31:24]` are ignored.
  - Counts range 0..4095.
- **FSM states and transitions:**
  - IDLE → HDR accept → LOAD_RECUR if `n_recur != 0`, else LOAD_STATE if `n_state != 0`, else FLUSH.
  - LOAD_RECUR: data word k is written to InexRecur address k, k = 0..`n_recur`-1. After word `n_recur`-1 the FSM goes to LOAD_STATE, or to FLUSH if `n_state == 0`.
  - LOAD_STATE: word k is written to state address k with data `in_data[17:0]`; upper bits are discarded. After word `n_state`-1 the FSM goes to FLUSH.
  - FLUSH: one cycle; the last write is visible on the ports.
  - START: `is_start` = 1 for exactly one cycle, then IDLE.
- **`in_ready`:** 1 in IDLE, LOAD_RECUR and LOAD_STATE; 0 in FLUSH and START.
- **Write ports:**
  - Registered. The write enable is high only in the cycle after the accepting handshake.
  - Address and data hold their last value while the enable is low.
  - The two enables are never high together.
- **Address counter:** ADDR_W bits, cleared on header acceptance and again at the LOAD_RECUR → LOAD_STATE switch. It never wraps, since the count is ≤ 4095 and the last address is ≤ 4094.
- **Stream stalls:** a gap in `in_valid` stalls the FSM in place with no write and no timeout.
- **Reset:** asserting reset mid-load aborts the load. The partial regfile contents are left as written. The next transfer is treated as a header.

## Timing
- Reset values: `in_ready` = 0 while `rst_n` = 0, then 1 (IDLE). All write enables, addresses and data = 0. `is_start` = 0. `busy_o` = 0.
- Write latency: handshake at edge t → enable high during cycle t+1; the regfile commits at the end of t+1.
- Start latency: last data word (or a zero-count header) accepted at edge t → FLUSH in cycle t+1 → `is_start` high in cycle t+2. `in_ready` returns to 1 in cycle t+3.
- Throughput: one word per cycle with no bubbles between header, recur and state phases.
- `busy_o` drops in the cycle after START.

## Structure
- Shared package `accel_pkg` holds:
  - the FSM state enum (IDLE, LOAD_RECUR, LOAD_STATE, FLUSH, START);
  - the header field bit positions;
  - the `ADDR_W`, `RECUR_W` and `STATE_W` defaults, which `accelerator_top` uses too.
- Single flat module; no sub-module.
- `top` instantiates `task_loader` in front of `accelerator_top` and removes the direct `ran_*` and `is_start` pins from its own port list.

## Test plan
- Header `0x0000_2003` (n_recur = 3, n_state = 2), then data A0..A2, S0..S1 sent back-to-back → InexRecur writes addr 0/1/2 = A0/A1/A2; state writes addr 0/1 = S0[17:0], S1[17:0]. `is_start` pulses exactly once, 2 cycles after S1 is accepted.
- Header `0x0000_0000` → no write enables; `is_start` high at t+2; `busy_o` high for t+1..t+2.
- Header n_recur = 2, n_state = 0 with `in_valid` toggled every other cycle → 2 InexRecur writes with no state write; stalls cause no spurious enables.
- State word `0xFFFF_FFFF` → `ran_w_data_state_external` = `0x3FFFF`.
- `rst_n` pulsed low after 1 of 3 recur words → all outputs return to reset values immediately; no `is_start`. A fresh header then loads from address 0.
- `in_valid` held high during FLUSH/START → `in_ready` = 0 there and no word is consumed; the next word is accepted in IDLE as a header.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared accelerator definitions: regfile widths, loader FSM states and
// stream header field layout.
package accel_pkg;

  // Default widths, shared with accelerator_top.
  localparam int unsigned DEF_ADDR_W  = 12;
  localparam int unsigned DEF_RECUR_W = 32;
  localparam int unsigned DEF_STATE_W = 18;

  // Header word layout: {ignored[31:24], n_state[23:12], n_recur[11:0]}.
  localparam int unsigned HDR_NRECUR_LSB = 0;
  localparam int unsigned HDR_NSTATE_LSB = 12;
  localparam int unsigned HDR_FIELD_W    = 12;

  // Loader FSM states; header acceptance happens in IDLE.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD_RECUR = 3'd1,
    LOAD_STATE = 3'd2,
    FLUSH      = 3'd3,
    START      = 3'd4
  } load_state_e;

endpackage : accel_pkg

// File: rtl/task_loader.sv
// task_loader: turns a host word stream (header, InexRecur words, state
// words) into regfile write-port traffic and fires a one-cycle is_start
// once the final write has been committed.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   in_valid, in_data, in_ready stream word handshake
//   ran_we/w_addr/w_data_InexRecur        InexRecur write port (registered)
//   ran_we/w_addr/w_data_state_external   state write port (registered)
//   is_start                    one-cycle start pulse
//   busy_o                      high from header acceptance through START
module task_loader
  import accel_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned RECUR_W = DEF_RECUR_W,
  parameter int unsigned STATE_W = DEF_STATE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [RECUR_W-1:0] in_data,
  output logic               in_ready,
  output logic               ran_we_InexRecur,
  output logic [ADDR_W-1:0]  ran_w_addr_InexRecur,
  output logic [RECUR_W-1:0] ran_w_data_InexRecur,
  output logic               ran_we_state_external,
  output logic [ADDR_W-1:0]  ran_w_addr_state_external,
  output logic [STATE_W-1:0] ran_w_data_state_external,
  output logic               is_start,
  output logic               busy_o
);

  load_state_e       state;
  logic [ADDR_W-1:0] n_recur;
  logic [ADDR_W-1:0] n_state;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] hdr_recur;
  logic [ADDR_W-1:0] hdr_state;
  logic              accept;

  assign accept    = in_valid && in_ready;
  assign hdr_recur = in_data[HDR_NRECUR_LSB +: ADDR_W];
  assign hdr_state = in_data[HDR_NSTATE_LSB +: ADDR_W];

  // Loader FSM with registered outputs. in_ready is computed from the
  // state being entered so it is valid in the same cycle as that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                     <= IDLE;
      n_recur                   <= '0;
      n_state                   <= '0;
      cnt                       <= '0;
      in_ready                  <= 1'b0;
      ran_we_InexRecur          <= 1'b0;
      ran_w_addr_InexRecur      <= '0;
      ran_w_data_InexRecur      <= '0;
      ran_we_state_external     <= 1'b0;
      ran_w_addr_state_external <= '0;
      ran_w_data_state_external <= '0;
      is_start                  <= 1'b0;
      busy_o                    <= 1'b0;
    end else begin
      ran_we_InexRecur      <= 1'b0;
      ran_we_state_external <= 1'b0;
      is_start              <= 1'b0;

      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            n_recur <= hdr_recur;
            n_state <= hdr_state;
            cnt     <= '0;
            busy_o  <= 1'b1;
            if (hdr_recur != '0) begin
              state <= LOAD_RECUR;
            end else if (hdr_state != '0) begin
              state <= LOAD_STATE;
            end else begin
              state    <= FLUSH;
              in_ready <= 1'b0;
            end
          end
        end

        LOAD_RECUR: begin
          if (accept) begin
            ran_we_InexRecur     <= 1'b1;
            ran_w_addr_InexRecur <= cnt;
            ran_w_data_InexRecur <= in_data;
            if (cnt == n_recur - ADDR_W'(1)) begin
              // Address restarts at 0 for the state phase.
              cnt <= '0;
              if (n_state != '0) begin
                state <= LOAD_STATE;
              end else begin
                state    <= FLUSH;
                in_ready <= 1'b0;
              end
            end else begin
              cnt <= cnt + ADDR_W'(1);
            end
          end
        end

        LOAD_STATE: begin
          if (accept) begin
            ran_we_state_external     <= 1'b1;
            ran_w_addr_state_external <= cnt;
            ran_w_data_state_external <= in_data[STATE_W-1:0];
            if (cnt == n_state - ADDR_W'(1)) begin
              state    <= FLUSH;
              in_ready <= 1'b0;
            end else begin
              cnt <= cnt + ADDR_W'(1);
            end
          end
        end

        // Last write is on the ports this cycle; start fires next.
        FLUSH: begin
          state    <= START;
          is_start <= 1'b1;
        end

        START: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          busy_o   <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          busy_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule : task_loader
